// File: rtl/jk_pattern_driver.sv
// rtl/jk_pattern_driver.sv - JK flip-flop stimulus generator and q checker
//
// Takes a WIDTH-bit target pattern over a valid/ready handshake, drives an
// external JK flop LSB first with reset/j/k, and checks the returned q two
// cycles after each j/k pair is presented.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   pat_valid/ready     pattern handshake (ready only while idle)
//   pat_data            target q sequence, LSB first
//   ff_reset/j/k        registered stimulus to the external flop
//   ff_q                q returned by the external flop
//   busy, done          transaction in progress / one-cycle completion pulse
//   err, mismatch_cnt   sticky mismatch flag / saturating mismatch count

module jk_pattern_driver #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [WIDTH-1:0] pat_data,
  output logic             ff_reset,
  output logic             ff_j,
  output logic             ff_k,
  input  logic             ff_q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] mismatch_cnt
);

  localparam int IDX_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, INIT, DRIVE, DRAIN} state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] shreg;
  logic [IDX_W-1:0] idx;
  logic             exp_q;
  logic [1:0]       pipe_t;
  logic [1:0]       pipe_v;

  logic accept;
  logic present;
  logic bit_t;
  logic nxt_j;
  logic nxt_k;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The j/k pair registered on the edge leaving INIT carries bit 0, so DRIVE
  // spends WIDTH cycles showing bits 0..WIDTH-1; idx counts bits issued.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    present    = 1'b0;
    bit_t      = shreg[0];
    nxt_j      = 1'b0;
    nxt_k      = 1'b0;
    case (state)
      IDLE: begin
        if (pat_valid && pat_ready) begin
          accept     = 1'b1;
          next_state = INIT;
        end
      end
      INIT: begin
        present    = 1'b1;
        next_state = DRIVE;
      end
      DRIVE: begin
        if (idx == IDX_W'(WIDTH)) begin
          next_state = DRAIN;
        end else begin
          present = 1'b1;
        end
      end
      DRAIN: begin
        if (idx == IDX_W'(1)) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase

    // Excitation uses the modelled q (exp_q), never ff_q.
    if (present) begin
      if (MODE == 0) begin
        nxt_j = bit_t;
        nxt_k = ~bit_t;
      end else begin
        nxt_j = bit_t ^ exp_q;
        nxt_k = bit_t ^ exp_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_ready    <= 1'b1;
      ff_reset     <= 1'b1;
      ff_j         <= 1'b0;
      ff_k         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      mismatch_cnt <= '0;
      shreg        <= '0;
      idx          <= '0;
      exp_q        <= 1'b0;
      pipe_t       <= '0;
      pipe_v       <= '0;
    end else begin
      pat_ready <= (next_state == IDLE);
      busy      <= (next_state != IDLE);
      ff_reset  <= (next_state == INIT);
      ff_j      <= nxt_j;
      ff_k      <= nxt_k;
      done      <= (state == DRAIN) && (next_state == IDLE);

      // Stage 1 holds the target pushed two edges ago, which is what the
      // flop should show now (one edge to sample j/k, one to read q back).
      pipe_t <= {pipe_t[0], bit_t};
      pipe_v <= {pipe_v[0], present};

      if (present) begin
        exp_q <= bit_t;
        shreg <= shreg >> 1;
        idx   <= idx + IDX_W'(1);
      end else if (state == DRIVE) begin
        idx <= '0;
      end else if (state == DRAIN) begin
        idx <= idx + IDX_W'(1);
      end

      if (pipe_v[1] && (ff_q != pipe_t[1])) begin
        err <= 1'b1;
        if (mismatch_cnt != {CNT_W{1'b1}}) begin
          mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        end
      end

      if (accept) begin
        shreg        <= pat_data;
        idx          <= '0;
        exp_q        <= 1'b0;
        err          <= 1'b0;
        mismatch_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_jk_pattern_driver.sv
// tb/tb_jk_pattern_driver.sv - directed table-driven bench for jk_pattern_driver

module tb_jk_pattern_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pat_valid = 1'b0;
  logic [7:0] pat_data = 8'h00;
  logic       stuck = 1'b0;

  logic       r0, fr0, j0, k0, q0, busy0, done0, err0;
  logic [5:0] cnt0;
  logic       r1, fr1, j1, k1, q1, busy1, done1, err1;
  logic [5:0] cnt1;
  logic       r2, fr2, j2, k2, q2, busy2, done2, err2;
  logic [1:0] cnt2;
  logic       fq0 = 1'b0, fq1 = 1'b0, fq2 = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jk_pattern_driver #(.WIDTH(8), .MODE(0), .CNT_W(6)) dut0 (
    .clk(clk), .reset(reset), .pat_valid(pat_valid), .pat_ready(r0),
    .pat_data(pat_data), .ff_reset(fr0), .ff_j(j0), .ff_k(k0), .ff_q(q0),
    .busy(busy0), .done(done0), .err(err0), .mismatch_cnt(cnt0));

  jk_pattern_driver #(.WIDTH(8), .MODE(1), .CNT_W(6)) dut1 (
    .clk(clk), .reset(reset), .pat_valid(pat_valid), .pat_ready(r1),
    .pat_data(pat_data), .ff_reset(fr1), .ff_j(j1), .ff_k(k1), .ff_q(q1),
    .busy(busy1), .done(done1), .err(err1), .mismatch_cnt(cnt1));

  jk_pattern_driver #(.WIDTH(8), .MODE(0), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .pat_valid(pat_valid), .pat_ready(r2),
    .pat_data(pat_data), .ff_reset(fr2), .ff_j(j2), .ff_k(k2), .ff_q(q2),
    .busy(busy2), .done(done2), .err(err2), .mismatch_cnt(cnt2));

  // Reference JK flops; q0/q2 can be forced stuck at 0.
  always @(posedge clk) begin
    if (fr0) fq0 <= 1'b0;
    else case ({j0, k0})
      2'b10: fq0 <= 1'b1;
      2'b01: fq0 <= 1'b0;
      2'b11: fq0 <= ~fq0;
      default: ;
    endcase
    if (fr1) fq1 <= 1'b0;
    else case ({j1, k1})
      2'b10: fq1 <= 1'b1;
      2'b01: fq1 <= 1'b0;
      2'b11: fq1 <= ~fq1;
      default: ;
    endcase
    if (fr2) fq2 <= 1'b0;
    else case ({j2, k2})
      2'b10: fq2 <= 1'b1;
      2'b01: fq2 <= 1'b0;
      2'b11: fq2 <= ~fq2;
      default: ;
    endcase
  end

  assign q0 = stuck ? 1'b0 : fq0;
  assign q1 = fq1;
  assign q2 = stuck ? 1'b0 : fq2;

  typedef struct {
    logic [7:0] pat;
    logic       stuck;
    logic [7:0] j0;
    logic [7:0] k0;
    logic [7:0] jk1;
    logic [5:0] cnt0;
    logic [1:0] cnt2;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts at a negedge with the drivers idle; returns at the negedge where
  // done is high (or after the cycle budget). Cycle c = negedge after the
  // c-th posedge following the accept edge.
  task automatic run_txn(input logic [7:0] p, output int done_cyc,
                         output logic [7:0] gj0, output logic [7:0] gk0,
                         output logic [7:0] gj1, output logic [7:0] gk1,
                         output logic [7:0] gq1);
    pat_valid = 1'b1;
    pat_data  = p;
    @(posedge clk);
    @(negedge clk);
    pat_valid = 1'b0;
    done_cyc = 0;
    gj0 = '0; gk0 = '0; gj1 = '0; gk1 = '0; gq1 = '0;
    chk("init_ff_reset", fr0, 1'b1);
    chk("init_ready", r0, 1'b0);
    chk("init_busy", busy0, 1'b1);
    for (int c = 0; c <= 20; c++) begin
      if (c >= 1 && c <= 8) begin
        gj0[c-1] = j0; gk0[c-1] = k0;
        gj1[c-1] = j1; gk1[c-1] = k1;
      end
      if (c >= 2 && c <= 9) gq1[c-2] = fq1;
      if (done0) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int ndone;
    logic [7:0] gj0, gk0, gj1, gk1, gq1;

    tbl[0] = '{8'hA5, 1'b0, 8'hA5, 8'h5A, 8'hEF, 6'd0, 2'd0};
    tbl[1] = '{8'h0F, 1'b0, 8'h0F, 8'hF0, 8'h11, 6'd0, 2'd0};
    tbl[2] = '{8'hFF, 1'b1, 8'hFF, 8'h00, 8'h01, 6'd8, 2'd3};
    tbl[3] = '{8'h00, 1'b1, 8'h00, 8'hFF, 8'h00, 6'd0, 2'd0};
    tbl[4] = '{8'h3C, 1'b0, 8'h3C, 8'hC3, 8'h44, 6'd0, 2'd0};
    tbl[5] = '{8'h81, 1'b1, 8'h81, 8'h7E, 8'h83, 6'd2, 2'd2};

    // Reset held for three edges
    repeat (3) @(negedge clk);
    chk("rst_ff_reset", fr0, 1'b1);
    chk("rst_ready", r0, 1'b1);
    chk("rst_jk", {j0, k0}, 2'b00);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_err", err0, 1'b0);
    chk("rst_cnt", cnt0, 6'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ff_reset", fr0, 1'b0);
    chk("idle_ready", r0, 1'b1);
    chk("idle_busy", busy0, 1'b0);

    // Table-driven transactions on all three drivers in parallel
    for (int i = 0; i < 6; i++) begin
      stuck = tbl[i].stuck;
      run_txn(tbl[i].pat, dc, gj0, gk0, gj1, gk1, gq1);
      chk($sformatf("v%0d_done_cyc", i), dc, 11);
      chk($sformatf("v%0d_j0", i), gj0, tbl[i].j0);
      chk($sformatf("v%0d_k0", i), gk0, tbl[i].k0);
      chk($sformatf("v%0d_j1", i), gj1, tbl[i].jk1);
      chk($sformatf("v%0d_k1", i), gk1, tbl[i].jk1);
      chk($sformatf("v%0d_q1", i), gq1, tbl[i].pat);
      chk($sformatf("v%0d_cnt0", i), cnt0, tbl[i].cnt0);
      chk($sformatf("v%0d_err0", i), err0, tbl[i].cnt0 != 6'd0);
      chk($sformatf("v%0d_cnt2", i), cnt2, tbl[i].cnt2);
      chk($sformatf("v%0d_err1", i), {err1, cnt1}, 7'd0);
      chk($sformatf("v%0d_ready_at_done", i), r0, 1'b1);
      chk($sformatf("v%0d_busy_at_done", i), busy0, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done0, 1'b0);
    end

    // Back-to-back: valid held high, second accepted in the done cycle
    stuck = 1'b1;
    pat_valid = 1'b1;
    pat_data = 8'h0F;
    @(posedge clk);
    @(negedge clk);
    pat_data = 8'hF0;
    dc = 0;
    for (int c = 0; c <= 20; c++) begin
      if (done0) begin dc = c; break; end
      @(negedge clk);
    end
    chk("b2b_first_done_cyc", dc, 11);
    chk("b2b_first_cnt", cnt0, 6'd4);
    chk("b2b_first_err", err0, 1'b1);
    chk("b2b_first_cnt2", cnt2, 2'd3);
    chk("b2b_ready_in_done", r0, 1'b1);
    @(negedge clk);
    pat_valid = 1'b0;
    stuck = 1'b0;
    chk("b2b_second_accept_err", err0, 1'b0);
    chk("b2b_second_accept_cnt", cnt0, 6'd0);
    chk("b2b_second_init", {fr0, r0, busy0, done0}, 4'b1010);
    dc = 0;
    gj0 = '0;
    for (int c = 0; c <= 20; c++) begin
      if (c >= 1 && c <= 8) gj0[c-1] = j0;
      if (done0) begin dc = c; break; end
      @(negedge clk);
    end
    chk("b2b_second_done_cyc", dc, 11);
    chk("b2b_second_j0", gj0, 8'hF0);
    chk("b2b_second_err", {err0, cnt0}, 7'd0);
    @(negedge clk);

    // Reset during DRIVE bit 3 with a stuck flop already mismatching
    stuck = 1'b1;
    pat_valid = 1'b1;
    pat_data = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    pat_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_bit3_j", {j0, k0}, 2'b10);
    chk("abort_pre_err", err0, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ff_reset", fr0, 1'b1);
    chk("abort_jk", {j0, k0}, 2'b00);
    chk("abort_flags", {busy0, done0, err0, r0}, 4'b0001);
    chk("abort_cnt", cnt0, 6'd0);
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done0 || err0) ndone++;
    end
    chk("abort_no_done_or_check", ndone, 0);
    stuck = 1'b0;
    run_txn(8'hA5, dc, gj0, gk0, gj1, gk1, gq1);
    chk("after_abort_done_cyc", dc, 11);
    chk("after_abort_j0", gj0, 8'hA5);
    chk("after_abort_err", {err0, cnt0}, 7'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
